// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a registered grant index and hold-time limited ownership.
// The holder keeps the grant until it drops its request or, while others wait, MAX_HOLD cycles pass.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic [7:0] hold_cnt,
    output logic       preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;
    logic [7:0] others;

    // First set bit of v scanning upward from p with wrap-around; only meaningful when v != 0.
    function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] r;
        logic [2:0] k;
        logic       found;
        r     = p;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = p + 3'(i);
            if (!found && v[k]) begin
                r     = k;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        others    = req & ~(8'd1 << idx_q);
        case (state_q)
            IDLE: begin
                if (req != 8'd0) begin
                    state_d = BUSY;
                    idx_d   = pick(req, ptr_q);
                    ptr_d   = pick(req, ptr_q) + 3'd1;
                    hold_d  = 8'd0;
                end
            end
            BUSY: begin
                if (!req[idx_q]) begin
                    if (others != 8'd0) begin
                        idx_d  = pick(others, ptr_q);
                        ptr_d  = pick(others, ptr_q) + 3'd1;
                        hold_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                        hold_d  = 8'd0;
                    end
                end else if (hold_q == HOLD_LIM && others != 8'd0) begin
                    // Hold limit reached with others waiting: forced rotation.
                    idx_d     = pick(others, ptr_q);
                    ptr_d     = pick(others, ptr_q) + 3'd1;
                    hold_d    = 8'd0;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_valid = (state_q == BUSY);
    assign gnt_idx   = idx_q;
    assign gnt       = gnt_valid ? (8'd1 << idx_q) : 8'd0;
    assign hold_cnt  = hold_q;
    assign preempt   = preempt_q;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter for a shared resource.
- Selects one requester and drives a registered 3-bit grant index, decoded 3-to-8 into a one-hot grant vector.
- Holds a grant until the owner drops its request or a hold-time limit forces rotation.
- Sits in front of any shared datapath (bus, register-file port, decoder-selected unit) that the team's one-hot select logic drives.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may keep the grant while others wait; legal 1..255.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  8  request vector, bit k = requester k
gnt  output  8  one-hot grant, registered; all-zero when idle
gnt_idx  output  3  binary index of current holder; 0 when idle
gnt_valid  output  1  high while any grant is active
hold_cnt  output  8  cycles current holder has held grant minus 1; saturates at MAX_HOLD-1
preempt  output  1  one-cycle pulse in first cycle of a grant caused by hold-time expiry

Behaviour:
- Reset (rst=1 at rising edge, overrides everything incl. active grant):
  - state=IDLE, ptr=0.
  - gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, preempt=0.
- Internal ptr[2:0] = search start index. After any grant to index h, ptr becomes h+1 mod 8.
- Arbitration function pick(v, p): first set bit of v scanning p, p+1, ..., 7, 0, ..., p-1 (wrap-around).
- gnt is always the 3-to-8 decode of gnt_idx ANDed with gnt_valid; never multi-hot.
- States: IDLE, BUSY.
- IDLE, req==0: stay IDLE; outputs remain zero.
- IDLE, req!=0 at edge: h=pick(req,ptr); go BUSY, gnt_idx=h, gnt_valid=1, hold_cnt=0, preempt=0, ptr=h+1.
  - Latency: grant visible in the cycle after req is sampled.
- BUSY with holder h; let others = req with bit h cleared.
  - Release (req[h]==0):
    - If others!=0: grant pick(others,ptr) at the same edge, no idle gap, hold_cnt=0, preempt=0.
    - Else: go IDLE; all outputs zero.
  - Expiry (req[h]==1, hold_cnt==MAX_HOLD-1, others!=0): grant pick(others,ptr), hold_cnt=0, preempt=1 for that one cycle.
  - Otherwise (req[h]==1, hold_cnt<MAX_HOLD-1, or no others waiting): keep h; hold_cnt increments, saturating at MAX_HOLD-1; preempt=0.
- preempt is 0 in every cycle other than the first cycle of an expiry-caused grant.
- Requests appearing or vanishing on non-holder bits never disturb the current holder before expiry.
- MAX_HOLD=1: under contention the grant rotates every cycle, preempt=1 on each rotation.
- Arithmetic: hold_cnt is unsigned 8-bit; ptr wraps modulo 8 (7+1 -> 0).

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, hold_cnt=0 throughout.
- After reset, req=8'b0001_0100 held -> next cycle gnt=8'h04, gnt_idx=2; drop bit 2 -> following cycle gnt=8'h10, gnt_idx=4, no idle cycle; drop all -> gnt=0.
- Wrap-around: grant idx 7, release, req=8'b1000_0011 -> next grant idx 0, then idx 1 on release, then idx 7.
- Expiry, MAX_HOLD=8: req=8'h03 held constantly -> idx0 granted for 8 cycles (hold_cnt 0..7), then idx1 with preempt=1 for exactly one cycle, then idx0 again after 8 more cycles.
- Lone holder: req=8'h20 held 20 cycles -> gnt=8'h20 continuously, hold_cnt saturates at 7, preempt never asserts.
- Reset mid-grant: holder idx 3 with hold_cnt=4, assert rst one cycle while req=8'hFF -> next cycle all outputs 0; after rst drops, first grant is idx 0 (ptr reset).
